// File: rtl/im_pkg.sv
// im_pkg: shared constants for the instruction store / fetch sequencer.
// Holds the FSM state encoding and the default geometry of the store.
package im_pkg;

   // Default geometry of the instruction store
   localparam int IM_IW_WIDTH_DEF = 26;
   localparam int IM_DEPTH_DEF    = 32;

   // FSM state type and encoding (plain constants for legacy tools)
   typedef logic [1:0] im_state_t;

   localparam im_state_t IM_IDLE = 2'd0;
   localparam im_state_t IM_LOAD = 2'd1;
   localparam im_state_t IM_RUN  = 2'd2;
   localparam im_state_t IM_HALT = 2'd3;

endpackage : im_pkg

// File: rtl/im_ram.sv
// im_ram: single-port synchronous instruction RAM, DEPTH x IW_WIDTH.
// One shared address port; a write in the same cycle wins over a read.
// The read data register sits behind an asynchronous reset so the fetched
// word output is zero out of reset, while the array itself is never cleared.
module im_ram
   import im_pkg::*;
#(
   parameter int  IW_WIDTH = IM_IW_WIDTH_DEF,
   parameter int  DEPTH    = IM_DEPTH_DEF,
   localparam int AW       = $clog2(DEPTH)
)(
   input  logic                clk,
   input  logic                i_rst_n,
   input  logic                i_we,
   input  logic                i_re,
   input  logic [AW-1:0]       i_addr,
   input  logic [IW_WIDTH-1:0] i_wdata,
   output logic [IW_WIDTH-1:0] o_rdata
);

   logic [IW_WIDTH-1:0] r_mem [DEPTH];
   logic [IW_WIDTH-1:0] r_rdata;

   // Array write; contents survive reset so a program is retained in the RAM
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
   end

   // Registered read; holds its value on cycles without a read
   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rdata <= '0;
      end else if (i_re && !i_we) begin
         r_rdata <= r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;

endmodule : im_ram

// File: rtl/inst_mem_sequencer.sv
// inst_mem_sequencer: instruction store and fetch sequencer for the IPU
// control path. A host loads a program through a valid/ready port, then a
// run pulse fetches one word per cycle (one cycle read latency) towards the
// decoder, with stall, jump, halt-or-loop at end of program and a sticky
// error flag for load overflow, empty run and out-of-range jumps.
module inst_mem_sequencer
   import im_pkg::*;
#(
   parameter int  IW_WIDTH = IM_IW_WIDTH_DEF,
   parameter int  DEPTH    = IM_DEPTH_DEF,
   parameter bit  LOOP_EN  = 1'b0,
   localparam int AW       = $clog2(DEPTH)
)(
   input  logic                clk,
   input  logic                im_rst_n,
   input  logic                im_ld_start,
   input  logic                im_ld_valid,
   input  logic                im_ld_last,
   input  logic [IW_WIDTH-1:0] im_instLoad,
   output logic                im_ld_ready,
   input  logic                im_run,
   input  logic                im_stall,
   input  logic                im_jmp_en,
   input  logic [AW-1:0]       im_jmp_addr,
   output logic [IW_WIDTH-1:0] im_IW,
   output logic                im_IW_valid,
   output logic [AW-1:0]       im_pc,
   output logic [AW:0]         im_prog_len,
   output logic                im_done,
   output logic                im_err
);

   // Full-store marker in the AW+1 bit counter domain
   localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);

   // ---------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------
   im_state_t     r_state;
   logic [AW:0]   r_wptr;
   logic [AW:0]   r_prog_len;
   logic [AW-1:0] r_pc;
   logic [AW-1:0] r_pc_out;
   logic          r_valid;
   logic          r_done;
   logic          r_err;

   // ---------------------------------------------------------------------
   // Combinational decode
   // ---------------------------------------------------------------------
   logic          w_in_load;
   logic          w_in_idle_halt;
   logic          w_ld_ready;
   logic          w_wr_en;
   logic          w_ld_overflow;
   logic          w_run_start;
   logic          w_run_empty;
   logic          w_issue;
   logic          w_jmp_ok;
   logic          w_jmp_bad;
   logic          w_issue_last;
   logic          w_end_halt;
   logic [AW-1:0] w_issue_addr;
   logic [AW-1:0] w_next_pc;
   logic [AW-1:0] w_ram_addr;
   logic [IW_WIDTH-1:0] w_rdata;

   assign w_in_load      = (r_state == IM_LOAD);
   assign w_in_idle_halt = (r_state == IM_IDLE) || (r_state == IM_HALT);

   // Store accepts words until every slot has been written
   assign w_ld_ready     = w_in_load && (r_wptr < C_DEPTH);

   // A load start in the same cycle restarts the load, so the word is not taken
   assign w_wr_en        = w_ld_ready && im_ld_valid && !im_ld_start;
   assign w_ld_overflow  = w_in_load && !w_ld_ready && im_ld_valid && !im_ld_start;

   // Run request is only honoured from IDLE/HALT, and never against a load start
   assign w_run_start    = w_in_idle_halt && im_run && !im_ld_start;
   assign w_run_empty    = w_run_start && (r_prog_len == '0);

   // A fetch is issued every RUN cycle unless stalled or aborted by a new load
   assign w_issue        = (r_state == IM_RUN) && !im_ld_start && !im_stall;

   // Jump targets beyond the loaded program are flagged and ignored
   assign w_jmp_ok       = im_jmp_en && ({1'b0, im_jmp_addr} < r_prog_len);
   assign w_jmp_bad      = im_jmp_en && !w_jmp_ok;

   assign w_issue_addr   = w_jmp_ok ? im_jmp_addr : r_pc;
   assign w_issue_last   = ({1'b0, w_issue_addr} == (r_prog_len - 1'b1));
   assign w_end_halt     = w_issue && w_issue_last && !LOOP_EN;

   // After the last word either wrap to the start or step on (pc wraps mod DEPTH)
   assign w_next_pc      = (w_issue_last && LOOP_EN) ? '0 : (w_issue_addr + 1'b1);

   // Load and fetch never overlap, but the write still owns the port if they did
   assign w_ram_addr     = w_wr_en ? r_wptr[AW-1:0] : w_issue_addr;

   // ---------------------------------------------------------------------
   // Instruction RAM
   // ---------------------------------------------------------------------
   im_ram #(
      .IW_WIDTH (IW_WIDTH),
      .DEPTH    (DEPTH)
   ) u_ram (
      .clk     (clk),
      .i_rst_n (im_rst_n),
      .i_we    (w_wr_en),
      .i_re    (w_issue),
      .i_addr  (w_ram_addr),
      .i_wdata (im_instLoad),
      .o_rdata (w_rdata)
   );

   // ---------------------------------------------------------------------
   // Sequential logic
   // ---------------------------------------------------------------------

   // Main FSM: a load start overrides every state, including a same-cycle run
   always_ff @(posedge clk or negedge im_rst_n) begin
      if (!im_rst_n) begin
         r_state <= IM_IDLE;
      end else if (im_ld_start) begin
         r_state <= IM_LOAD;
      end else begin
         case (r_state)
            IM_LOAD: begin
               if (w_wr_en && im_ld_last) begin
                  r_state <= IM_IDLE;
               end
            end
            IM_IDLE, IM_HALT: begin
               if (w_run_empty) begin
                  r_state <= IM_IDLE;
               end else if (w_run_start) begin
                  r_state <= IM_RUN;
               end
            end
            IM_RUN: begin
               if (w_end_halt) begin
                  r_state <= IM_HALT;
               end
            end
            default: begin
               r_state <= IM_IDLE;
            end
         endcase
      end
   end

   // Load write pointer and program length; length only commits on the last word
   always_ff @(posedge clk or negedge im_rst_n) begin
      if (!im_rst_n) begin
         r_wptr     <= '0;
         r_prog_len <= '0;
      end else if (im_ld_start) begin
         r_wptr     <= '0;
         r_prog_len <= '0;
      end else if (w_wr_en) begin
         r_wptr <= r_wptr + 1'b1;
         if (im_ld_last) begin
            r_prog_len <= r_wptr + 1'b1;
         end
      end
   end

   // Program counter: restart at 0 on run, advance per issued fetch, hold on stall
   always_ff @(posedge clk or negedge im_rst_n) begin
      if (!im_rst_n) begin
         r_pc <= '0;
      end else if (w_run_start) begin
         r_pc <= '0;
      end else if (w_issue) begin
         r_pc <= w_next_pc;
      end
   end

   // Done follows entry to HALT; error is sticky until the next load start
   always_ff @(posedge clk or negedge im_rst_n) begin
      if (!im_rst_n) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else if (im_ld_start) begin
         r_done <= 1'b0;
         r_err  <= 1'b0;
      end else begin
         if (w_run_start) begin
            r_done <= 1'b0;
         end else if (w_end_halt) begin
            r_done <= 1'b1;
         end
         if (w_ld_overflow || w_run_empty || (w_issue && w_jmp_bad)) begin
            r_err <= 1'b1;
         end
      end
   end

   // Fetch output: valid pulses with the read data, pc tracks the word on im_IW
   always_ff @(posedge clk or negedge im_rst_n) begin
      if (!im_rst_n) begin
         r_valid  <= 1'b0;
         r_pc_out <= '0;
      end else begin
         r_valid <= w_issue;
         if (w_issue) begin
            r_pc_out <= w_issue_addr;
         end
      end
   end

   // ---------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------
   assign im_ld_ready = w_ld_ready;
   assign im_IW       = w_rdata;
   assign im_IW_valid = r_valid;
   assign im_pc       = r_pc_out;
   assign im_prog_len = r_prog_len;
   assign im_done     = r_done;
   assign im_err      = r_err;

endmodule : inst_mem_sequencer

// File: tb/tb_inst_mem_sequencer.sv
// tb_inst_mem_sequencer: self-checking bench for inst_mem_sequencer.
// Two instances share stimulus: one halting (LOOP_EN=0) and one looping.
module tb_inst_mem_sequencer;

   localparam int IW    = 26;
   localparam int DEPTH = 32;
   localparam int AW    = 5;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic          rst_n;
   logic          ld_start, ld_valid, ld_last, run, stall, jmp_en;
   logic [IW-1:0] ld_data;
   logic [AW-1:0] jmp_addr;

   logic          ld_ready, iw_valid, done, err;
   logic [IW-1:0] iw;
   logic [AW-1:0] pc;
   logic [AW:0]   prog_len;

   logic          l_ld_ready, l_iw_valid, l_done, l_err;
   logic [IW-1:0] l_iw;
   logic [AW-1:0] l_pc;
   logic [AW:0]   l_prog_len;

   int errors = 0;
   int checks = 0;

   // Reference model: loaded program contents and expected status
   logic [IW-1:0] m_mem [DEPTH];
   int            m_len;
   bit            m_err;
   bit            m_done;
   logic [IW-1:0] m_iw;
   int            m_pc_out;

   inst_mem_sequencer #(.IW_WIDTH(IW), .DEPTH(DEPTH), .LOOP_EN(1'b0)) dut (
      .clk(clk), .im_rst_n(rst_n), .im_ld_start(ld_start), .im_ld_valid(ld_valid),
      .im_ld_last(ld_last), .im_instLoad(ld_data), .im_ld_ready(ld_ready),
      .im_run(run), .im_stall(stall), .im_jmp_en(jmp_en), .im_jmp_addr(jmp_addr),
      .im_IW(iw), .im_IW_valid(iw_valid), .im_pc(pc), .im_prog_len(prog_len),
      .im_done(done), .im_err(err)
   );

   inst_mem_sequencer #(.IW_WIDTH(IW), .DEPTH(DEPTH), .LOOP_EN(1'b1)) dut_loop (
      .clk(clk), .im_rst_n(rst_n), .im_ld_start(ld_start), .im_ld_valid(ld_valid),
      .im_ld_last(ld_last), .im_instLoad(ld_data), .im_ld_ready(l_ld_ready),
      .im_run(run), .im_stall(stall), .im_jmp_en(jmp_en), .im_jmp_addr(jmp_addr),
      .im_IW(l_iw), .im_IW_valid(l_iw_valid), .im_pc(l_pc), .im_prog_len(l_prog_len),
      .im_done(l_done), .im_err(l_err)
   );

   // Advance one clock; outputs are sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      ld_start = 0; ld_valid = 0; ld_last = 0; ld_data = '0;
      run = 0; stall = 0; jmp_en = 0; jmp_addr = '0;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      clear_inputs();
      repeat (2) @(posedge clk);
      #3;
      rst_n = 1'b1;
      tick();
      m_len = 0; m_err = 0; m_done = 0;
   endtask

   // Load a program: sequential data from base, or random data with valid gaps
   task automatic load_program(input int len, input logic [IW-1:0] base, input bit rnd);
      ld_start = 1; tick(); ld_start = 0;
      m_err = 0; m_done = 0;
      for (int i = 0; i < len; i++) begin
         if (rnd) begin
            while ($urandom_range(0, 3) == 0) begin
               ld_valid = 0; ld_last = 0; tick();
            end
         end
         ld_valid = 1;
         ld_last  = (i == len - 1);
         ld_data  = rnd ? IW'($urandom) : base + IW'(i);
         m_mem[i] = ld_data;
         tick();
      end
      ld_valid = 0; ld_last = 0;
      m_len = len;
      $display("load: %0d words, word0=%h", len, m_mem[0]);
   endtask

   task automatic start_run();
      run = 1; tick(); run = 0;
   endtask

   task automatic test_reset();
      checks++;
      if ({ld_ready, iw_valid, iw, pc, prog_len, done, err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got rdy=%b v=%b iw=%h pc=%0d len=%0d done=%b err=%b, expected all 0",
                  ld_ready, iw_valid, iw, pc, prog_len, done, err);
      end
      checks++;
      if ({l_ld_ready, l_iw_valid, l_iw, l_pc, l_prog_len, l_done, l_err} !== '0) begin
         errors++;
         $display("FAIL reset_outputs_loop: got v=%b iw=%h pc=%0d, expected all 0", l_iw_valid, l_iw, l_pc);
      end
      $display("reset: outputs checked");
   endtask

   task automatic test_basic();
      load_program(4, 26'h0A0, 1'b0);
      checks++;
      if (prog_len !== 6'd4) begin
         errors++; $display("FAIL basic_len: got %0d expected 4", prog_len);
      end
      start_run();
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({iw_valid, iw, pc, done} !== {1'b1, m_mem[i], AW'(i), (i == 3)}) begin
            errors++;
            $display("FAIL basic_fetch%0d: got v=%b iw=%h pc=%0d done=%b expected v=1 iw=%h pc=%0d done=%b",
                     i, iw_valid, iw, pc, done, m_mem[i], i, (i == 3));
         end
      end
      tick();
      checks++;
      if ({iw_valid, iw, done} !== {1'b0, m_mem[3], 1'b1}) begin
         errors++;
         $display("FAIL basic_halt: got v=%b iw=%h done=%b expected v=0 iw=%h done=1", iw_valid, iw, done, m_mem[3]);
      end
      $display("basic: 4-word program fetched");
   endtask

   task automatic test_loop();
      load_program(3, 26'h100, 1'b0);
      start_run();
      for (int i = 0; i < 8; i++) begin
         tick();
         checks++;
         if ({l_iw_valid, l_iw, l_pc, l_done} !== {1'b1, m_mem[i % 3], AW'(i % 3), 1'b0}) begin
            errors++;
            $display("FAIL loop_fetch%0d: got v=%b iw=%h pc=%0d done=%b expected v=1 iw=%h pc=%0d done=0",
                     i, l_iw_valid, l_iw, l_pc, l_done, m_mem[i % 3], i % 3);
         end
      end
      checks++;
      if ({l_prog_len, l_err, l_ld_ready} !== {6'd3, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL loop_status: got len=%0d err=%b rdy=%b expected len=3 err=0 rdy=0", l_prog_len, l_err, l_ld_ready);
      end
      $display("loop: 8 fetches over 3-word program");
   endtask

   task automatic test_stall_jump();
      load_program(4, 26'h200, 1'b0);
      start_run();
      tick(); tick();
      checks++;
      if ({iw_valid, iw, pc} !== {1'b1, m_mem[1], AW'(1)}) begin
         errors++; $display("FAIL stall_pre: got v=%b iw=%h pc=%0d expected v=1 iw=%h pc=1", iw_valid, iw, pc, m_mem[1]);
      end
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({iw_valid, iw, pc} !== {1'b0, m_mem[1], AW'(1)}) begin
            errors++; $display("FAIL stall_hold%0d: got v=%b iw=%h pc=%0d expected v=0 iw=%h pc=1", i, iw_valid, iw, pc, m_mem[1]);
         end
      end
      stall = 0;
      tick();
      checks++;
      if ({iw_valid, iw, pc} !== {1'b1, m_mem[2], AW'(2)}) begin
         errors++; $display("FAIL stall_resume: got v=%b iw=%h pc=%0d expected v=1 iw=%h pc=2", iw_valid, iw, pc, m_mem[2]);
      end
      jmp_en = 1; jmp_addr = '0;
      tick();
      jmp_en = 0;
      checks++;
      if ({iw_valid, iw, pc, err} !== {1'b1, m_mem[0], AW'(0), 1'b0}) begin
         errors++; $display("FAIL jump_to0: got v=%b iw=%h pc=%0d err=%b expected v=1 iw=%h pc=0 err=0", iw_valid, iw, pc, err, m_mem[0]);
      end
      for (int k = 1; k < 4; k++) begin
         tick();
         checks++;
         if ({iw_valid, iw, pc, done} !== {1'b1, m_mem[k], AW'(k), (k == 3)}) begin
            errors++; $display("FAIL jump_seq%0d: got v=%b iw=%h pc=%0d done=%b", k, iw_valid, iw, pc, done);
         end
      end
      $display("stall_jump: stall held word1, jump returned to word0");
   endtask

   task automatic test_overflow();
      ld_start = 1; tick(); ld_start = 0;
      for (int i = 0; i < DEPTH; i++) begin
         checks++;
         if (ld_ready !== 1'b1) begin
            errors++; $display("FAIL ovf_ready%0d: got %b expected 1", i, ld_ready);
         end
         ld_valid = 1; ld_data = IW'(i); tick();
      end
      ld_valid = 0;
      checks++;
      if ({ld_ready, err, prog_len} !== {1'b0, 1'b0, 6'd0}) begin
         errors++; $display("FAIL ovf_full: got rdy=%b err=%b len=%0d expected rdy=0 err=0 len=0", ld_ready, err, prog_len);
      end
      ld_valid = 1; ld_last = 1; tick(); ld_valid = 0; ld_last = 0;
      checks++;
      if ({ld_ready, err, prog_len} !== {1'b0, 1'b1, 6'd0}) begin
         errors++; $display("FAIL ovf_drop: got rdy=%b err=%b len=%0d expected rdy=0 err=1 len=0", ld_ready, err, prog_len);
      end
      do_reset();
      checks++;
      if (err !== 1'b0) begin
         errors++; $display("FAIL ovf_reset_err: got %b expected 0", err);
      end
      start_run();
      checks++;
      if ({err, iw_valid, done, ld_ready} !== 4'b1000) begin
         errors++; $display("FAIL empty_run: got err=%b v=%b done=%b rdy=%b expected err=1 v=0 done=0 rdy=0", err, iw_valid, done, ld_ready);
      end
      tick();
      checks++;
      if ({err, iw_valid} !== 2'b10) begin
         errors++; $display("FAIL empty_run_idle: got err=%b v=%b expected err=1 v=0", err, iw_valid);
      end
      $display("overflow: 33rd word dropped, empty run flagged");
   endtask

   task automatic test_bad_jump();
      load_program(4, 26'h300, 1'b0);
      start_run();
      tick();
      jmp_en = 1; jmp_addr = AW'(7);
      tick();
      jmp_en = 0;
      checks++;
      if ({err, iw_valid, iw, pc} !== {1'b1, 1'b1, m_mem[1], AW'(1)}) begin
         errors++; $display("FAIL bad_jump: got err=%b v=%b iw=%h pc=%0d expected err=1 v=1 iw=%h pc=1", err, iw_valid, iw, pc, m_mem[1]);
      end
      tick();
      checks++;
      if ({err, iw, pc} !== {1'b1, m_mem[2], AW'(2)}) begin
         errors++; $display("FAIL bad_jump_seq: got err=%b iw=%h pc=%0d expected err=1 iw=%h pc=2", err, iw, pc, m_mem[2]);
      end
      ld_start = 1; run = 1; tick(); ld_start = 0; run = 0;
      checks++;
      if ({ld_ready, iw_valid, done, err} !== 4'b1000) begin
         errors++; $display("FAIL start_beats_run: got rdy=%b v=%b done=%b err=%b expected rdy=1 v=0 done=0 err=0", ld_ready, iw_valid, done, err);
      end
      $display("bad_jump: out-of-range jump flagged, load start aborted run");
   endtask

   task automatic test_async_reset();
      load_program(4, 26'h400, 1'b0);
      start_run();
      tick(); tick();
      checks++;
      if ({iw_valid, iw, pc} !== {1'b1, m_mem[1], AW'(1)}) begin
         errors++; $display("FAIL arst_pre: got v=%b iw=%h pc=%0d expected v=1 iw=%h pc=1", iw_valid, iw, pc, m_mem[1]);
      end
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({ld_ready, iw_valid, iw, pc, prog_len, done, err} !== '0) begin
         errors++; $display("FAIL arst_immediate: got v=%b iw=%h pc=%0d len=%0d done=%b err=%b expected all 0",
                            iw_valid, iw, pc, prog_len, done, err);
      end
      @(negedge clk);
      #2;
      rst_n = 1'b1;
      tick();
      m_len = 0; m_err = 0; m_done = 0;
      start_run();
      checks++;
      if ({err, iw_valid, prog_len} !== {1'b1, 1'b0, 6'd0}) begin
         errors++; $display("FAIL arst_run_empty: got err=%b v=%b len=%0d expected err=1 v=0 len=0", err, iw_valid, prog_len);
      end
      load_program(2, 26'h480, 1'b0);
      start_run();
      tick();
      checks++;
      if ({iw_valid, iw, pc, err} !== {1'b1, m_mem[0], AW'(0), 1'b0}) begin
         errors++; $display("FAIL arst_reload: got v=%b iw=%h pc=%0d err=%b expected v=1 iw=%h pc=0 err=0", iw_valid, iw, pc, err, m_mem[0]);
      end
      $display("async_reset: outputs cleared mid-run, reload fetched");
   endtask

   // Random programs with random stall/jump traffic against the model
   task automatic test_random();
      for (int it = 0; it < 8; it++) begin
         int  len;
         int  mpc;
         int  cyc;
         int  issue;
         int  fetched;
         bit  active;
         bit  exp_valid;
         len = $urandom_range(1, DEPTH);
         load_program(len, '0, 1'b1);
         checks++;
         if ({prog_len, err} !== {(AW+1)'(len), 1'b0}) begin
            errors++; $display("FAIL rand_load%0d: got len=%0d err=%b expected len=%0d err=0", it, prog_len, err, len);
         end
         start_run();
         mpc = 0; cyc = 0; active = 1; fetched = 0;
         while (active && cyc < 2000) begin
            stall    = (cyc != 0) && ($urandom_range(0, 3) == 0);
            jmp_en   = ($urandom_range(0, 5) == 0);
            jmp_addr = AW'($urandom_range(0, DEPTH - 1));
            exp_valid = 0;
            if (!stall) begin
               if (jmp_en && int'(jmp_addr) < m_len) begin
                  issue = int'(jmp_addr);
               end else begin
                  issue = mpc;
                  if (jmp_en) m_err = 1;
               end
               exp_valid = 1;
               m_iw      = m_mem[issue];
               m_pc_out  = issue;
               fetched++;
               if (issue == m_len - 1) begin
                  active = 0;
                  m_done = 1;
               end else begin
                  mpc = issue + 1;
               end
            end
            tick();
            cyc++;
            checks++;
            if ({iw_valid, iw, pc, done, err} !== {exp_valid, m_iw, AW'(m_pc_out), m_done, m_err}) begin
               errors++;
               $display("FAIL rand%0d_cyc%0d: got v=%b iw=%h pc=%0d done=%b err=%b expected v=%b iw=%h pc=%0d done=%b err=%b",
                        it, cyc, iw_valid, iw, pc, done, err, exp_valid, m_iw, m_pc_out, m_done, m_err);
            end
         end
         stall = 0; jmp_en = 0;
         checks++;
         if (active) begin
            errors++; $display("FAIL rand%0d_budget: still running after %0d cycles, expected halt", it, cyc);
         end
         $display("random run %0d: len=%0d cycles=%0d fetches=%0d err=%b", it, len, cyc, fetched, m_err);
      end
   endtask

   initial begin
      rst_n = 1'b0;
      clear_inputs();
      do_reset();
      test_reset();
      test_basic();
      test_loop();
      test_stall_jump();
      test_overflow();
      test_bad_jump();
      test_async_reset();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1, "timeout");
   end

endmodule : tb_inst_mem_sequencer
